apb_arbiter: RTL

Two-master APB3 arbiter that shares the single system APB slave window (the `s_apb_*` bus) between the CPU-side master and a second requester such as the debug/DMA port. Requests are granted round-robin; the granted transfer is re-issued on the slave side as a clean APB setup/access sequence and its response is returned only to the owner. An optional watchdog terminates hung slave accesses with an error.

---
 rtl/apb_arbiter_pkg.sv | 33 +++
 rtl/apb_timeout_counter.sv | 29 ++
 rtl/apb_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/apb_arbiter_pkg.sv
// Shared types, grant IDs and default sizes for the two-master APB arbiter.
package apb_arbiter_pkg;

  localparam int DEFAULT_ADDR_WIDTH     = 32;
  localparam int DEFAULT_DATA_WIDTH     = 32;
  localparam int DEFAULT_TIMEOUT_CYCLES = 255;
  localparam int TIMEOUT_COUNT_WIDTH    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  typedef logic grant_t;

  localparam grant_t GRANT_M0 = 1'b0;
  localparam grant_t GRANT_M1 = 1'b1;

  // Under contention the master that did not win last time gets the bus.
  function automatic grant_t pick_grant(input logic req_m0, input logic req_m1,
                                        input grant_t last_grant);
    if (req_m0 && req_m1) begin
      return (last_grant == GRANT_M0) ? GRANT_M1 : GRANT_M0;
    end else if (req_m1) begin
      return GRANT_M1;
    end else begin
      return GRANT_M0;
    end
  endfunction

endpackage

// File: rtl/apb_timeout_counter.sv
// Access-phase watchdog counter: cleared in SETUP, counts stalled ACCESS cycles,
// flags expiry once the count reaches LIMIT.
module apb_timeout_counter
  import apb_arbiter_pkg::*;
#(
  parameter int LIMIT = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TIMEOUT_COUNT_WIDTH-1:0] count;

  assign expired = (count == TIMEOUT_COUNT_WIDTH'(LIMIT));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + TIMEOUT_COUNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/apb_arbiter.sv
// Two-master APB3 arbiter: round-robin grant, clean slave-side replay, response to owner only.
// Define APB_ARBITER_TIMEOUT_EN to terminate hung slave accesses with an error.
module apb_arbiter
  import apb_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [ADDR_WIDTH-1:0] m0_apb_paddr,
  input  logic                  m0_apb_psel,
  input  logic                  m0_apb_penable,
  input  logic                  m0_apb_pwrite,
  input  logic [DATA_WIDTH-1:0] m0_apb_pwdata,
  output logic [DATA_WIDTH-1:0] m0_apb_prdata,
  output logic                  m0_apb_pready,
  output logic                  m0_apb_pslverror,
  input  logic [ADDR_WIDTH-1:0] m1_apb_paddr,
  input  logic                  m1_apb_psel,
  input  logic                  m1_apb_penable,
  input  logic                  m1_apb_pwrite,
  input  logic [DATA_WIDTH-1:0] m1_apb_pwdata,
  output logic [DATA_WIDTH-1:0] m1_apb_prdata,
  output logic                  m1_apb_pready,
  output logic                  m1_apb_pslverror,
  output logic [ADDR_WIDTH-1:0] s_apb_paddr,
  output logic                  s_apb_psel,
  output logic                  s_apb_penable,
  output logic                  s_apb_pwrite,
  output logic [DATA_WIDTH-1:0] s_apb_pwdata,
  input  logic [DATA_WIDTH-1:0] s_apb_prdata,
  input  logic                  s_apb_pready,
  input  logic                  s_apb_pslverror
);

  arb_state_t            state;
  grant_t                owner;
  grant_t                last_grant;
  grant_t                next_grant;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic                  timeout_expired;
  logic                  rsp_err;

  assign next_grant    = pick_grant(m0_apb_psel, m1_apb_psel, last_grant);
  assign m0_apb_prdata = prdata_q;
  assign m1_apb_prdata = prdata_q;
  assign rsp_err       = s_apb_pready ? s_apb_pslverror : 1'b1;

  // Requests are psel alone, so the masters' own access-phase flag is never looked at.
  logic unused_penable;
  assign unused_penable = m0_apb_penable | m1_apb_penable;

`ifdef APB_ARBITER_TIMEOUT_EN
  apb_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .resetn (resetn),
    .clear  (state == SETUP),
    .enable ((state == ACCESS) && !s_apb_pready),
    .expired(timeout_expired)
  );
`else
  assign timeout_expired = 1'b0;
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // Slave pready takes priority over a watchdog expiry arriving in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state            <= IDLE;
      owner            <= GRANT_M0;
      last_grant       <= GRANT_M1;
      prdata_q         <= '0;
      s_apb_paddr      <= '0;
      s_apb_psel       <= 1'b0;
      s_apb_penable    <= 1'b0;
      s_apb_pwrite     <= 1'b0;
      s_apb_pwdata     <= '0;
      m0_apb_pready    <= 1'b0;
      m1_apb_pready    <= 1'b0;
      m0_apb_pslverror <= 1'b0;
      m1_apb_pslverror <= 1'b0;
    end else begin
      m0_apb_pready    <= 1'b0;
      m1_apb_pready    <= 1'b0;
      m0_apb_pslverror <= 1'b0;
      m1_apb_pslverror <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_apb_psel || m1_apb_psel) begin
            owner        <= next_grant;
            s_apb_paddr  <= (next_grant == GRANT_M1) ? m1_apb_paddr  : m0_apb_paddr;
            s_apb_pwrite <= (next_grant == GRANT_M1) ? m1_apb_pwrite : m0_apb_pwrite;
            s_apb_pwdata <= (next_grant == GRANT_M1) ? m1_apb_pwdata : m0_apb_pwdata;
            s_apb_psel   <= 1'b1;
            state        <= SETUP;
          end
        end
        SETUP: begin
          s_apb_penable <= 1'b1;
          state         <= ACCESS;
        end
        ACCESS: begin
          if (s_apb_pready || timeout_expired) begin
            s_apb_psel    <= 1'b0;
            s_apb_penable <= 1'b0;
            prdata_q      <= (s_apb_pready && !s_apb_pwrite) ? s_apb_prdata : '0;
            state         <= DONE;
            if (owner == GRANT_M1) begin
              m1_apb_pready    <= 1'b1;
              m1_apb_pslverror <= rsp_err;
            end else begin
              m0_apb_pready    <= 1'b1;
              m0_apb_pslverror <= rsp_err;
            end
          end
        end
        DONE: begin
          last_grant <= owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
